// File: rtl/axi_llc_lock_sched.sv
// Lock-box scheduler: round-robin arbitration between write and read
// descriptor streams, lookup-then-lock, then forward downstream.
module axi_llc_lock_sched #(
  parameter int unsigned IndexLength      = 8,
  parameter int unsigned SetAssociativity = 8,
  parameter int unsigned DescWidth        = 64,
  parameter int unsigned StallCntWidth    = 16,
  parameter int unsigned StarveThresh     = 1024
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [DescWidth-1:0]        w_desc_i,
  input  logic [IndexLength-1:0]      w_index_i,
  input  logic [SetAssociativity-1:0] w_way_i,
  input  logic                        w_valid_i,
  output logic                        w_ready_o,
  input  logic [DescWidth-1:0]        r_desc_i,
  input  logic [IndexLength-1:0]      r_index_i,
  input  logic [SetAssociativity-1:0] r_way_i,
  input  logic                        r_valid_i,
  output logic                        r_ready_o,
  output logic [IndexLength-1:0]      lock_index_o,
  output logic [SetAssociativity-1:0] lock_way_o,
  output logic                        lock_req_o,
  input  logic                        locked_i,
  output logic [DescWidth-1:0]        desc_o,
  output logic                        desc_src_o,
  output logic                        desc_valid_o,
  input  logic                        desc_ready_i,
  output logic                        busy_o,
  output logic [StallCntWidth-1:0]    stall_cnt_o,
  output logic                        starve_o
);

  typedef enum logic [1:0] {
    IDLE,
    CHECK,
    SEND
  } state_e;

  state_e                      state_q, state_d;
  logic                        rr_q, rr_d;
  logic [DescWidth-1:0]        desc_q, desc_d;
  logic [IndexLength-1:0]      index_q, index_d;
  logic [SetAssociativity-1:0] way_q, way_d;
  logic                        src_q, src_d;
  logic [StallCntWidth-1:0]    stall_q, stall_d;
  logic                        gnt_w, gnt_r;

  // rr_q=0 favours write, rr_q=1 favours read when both are valid
  assign gnt_w = w_valid_i && (!r_valid_i || !rr_q);
  assign gnt_r = r_valid_i && (!w_valid_i || rr_q);

  always_comb begin
    state_d      = state_q;
    rr_d         = rr_q;
    desc_d       = desc_q;
    index_d      = index_q;
    way_d        = way_q;
    src_d        = src_q;
    stall_d      = stall_q;
    w_ready_o    = 1'b0;
    r_ready_o    = 1'b0;
    lock_req_o   = 1'b0;
    desc_valid_o = 1'b0;
    unique case (state_q)
      IDLE: begin
        w_ready_o = gnt_w;
        r_ready_o = gnt_r;
        if (gnt_w) begin
          desc_d  = w_desc_i;
          index_d = w_index_i;
          way_d   = w_way_i;
          src_d   = 1'b0;
          stall_d = '0;
          rr_d    = 1'b1;
          state_d = CHECK;
        end else if (gnt_r) begin
          desc_d  = r_desc_i;
          index_d = r_index_i;
          way_d   = r_way_i;
          src_d   = 1'b1;
          stall_d = '0;
          rr_d    = 1'b0;
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (!locked_i) begin
          lock_req_o = 1'b1;
          state_d    = SEND;
        end else if (stall_q != '1) begin
          stall_d = stall_q + 1'b1;
        end
      end
      SEND: begin
        desc_valid_o = 1'b1;
        if (desc_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      rr_q    <= 1'b0;
      desc_q  <= '0;
      index_q <= '0;
      way_q   <= '0;
      src_q   <= 1'b0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      desc_q  <= desc_d;
      index_q <= index_d;
      way_q   <= way_d;
      src_q   <= src_d;
      stall_q <= stall_d;
    end
  end

  assign lock_index_o = index_q;
  assign lock_way_o   = way_q;
  assign desc_o       = desc_q;
  assign desc_src_o   = src_q;
  assign busy_o       = state_q != IDLE;
  assign stall_cnt_o  = stall_q;
  assign starve_o     = stall_q >= StallCntWidth'(StarveThresh);

endmodule

// File: tb/tb_axi_llc_lock_sched.sv
// Bench for axi_llc_lock_sched: scoreboard of accepted descriptors,
// grant-order model and directed lock/stall scenarios.
module tb_axi_llc_lock_sched;

  localparam int SCW = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] w_desc, r_desc, desc_o;
  logic [7:0]  w_index, r_index, lock_index;
  logic [7:0]  w_way, r_way, lock_way;
  logic        w_valid, w_ready, r_valid, r_ready;
  logic        lock_req, locked, desc_src, desc_valid, desc_ready;
  logic        busy, starve;
  logic [SCW-1:0] stall_cnt;

  int n_chk = 0;
  int n_err = 0;
  int n_lock = 0;
  int n_acc = 0;
  logic exp_ptr = 1'b0;
  logic [64:0] sb_q[$];

  always #5 clk = ~clk;

  axi_llc_lock_sched #(
    .StallCntWidth(SCW),
    .StarveThresh (10)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .w_desc_i    (w_desc),
    .w_index_i   (w_index),
    .w_way_i     (w_way),
    .w_valid_i   (w_valid),
    .w_ready_o   (w_ready),
    .r_desc_i    (r_desc),
    .r_index_i   (r_index),
    .r_way_i     (r_way),
    .r_valid_i   (r_valid),
    .r_ready_o   (r_ready),
    .lock_index_o(lock_index),
    .lock_way_o  (lock_way),
    .lock_req_o  (lock_req),
    .locked_i    (locked),
    .desc_o      (desc_o),
    .desc_src_o  (desc_src),
    .desc_valid_o(desc_valid),
    .desc_ready_i(desc_ready),
    .busy_o      (busy),
    .stall_cnt_o (stall_cnt),
    .starve_o    (starve)
  );

  task automatic chk(input string tag,
                     input logic [64:0] act,
                     input logic [64:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  // Negedge monitor: grant model, scoreboard push/pop, lock pulse count
  always @(negedge clk) begin
    if (rst) begin
      exp_ptr = 1'b0;
      sb_q.delete();
    end else begin
      if (lock_req) n_lock++;
      if ((w_valid && w_ready) || (r_valid && r_ready)) begin
        logic es;
        es = (w_valid && r_valid) ? exp_ptr : r_valid;
        chk("grant_src", {64'd0, r_ready}, {64'd0, es});
        chk("one_ready", {64'd0, w_ready & r_ready}, 65'd0);
        exp_ptr = ~r_ready;
        n_acc++;
        sb_q.push_back(r_ready ? {1'b1, r_desc} : {1'b0, w_desc});
      end
      if (desc_valid && desc_ready) begin
        if (sb_q.size() == 0) begin
          chk("sb_underflow", 65'd1, 65'd0);
        end else begin
          chk("sb_desc", {desc_src, desc_o}, sb_q.pop_front());
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    w_valid = 0; r_valid = 0; locked = 0; desc_ready = 1;
  endtask

  task automatic do_reset();
    cyc();
    rst = 1;
    idle_in();
    cyc();
    rst = 0;
  endtask

  initial begin
    rst = 1;
    w_desc = '0; r_desc = '0;
    w_index = '0; r_index = '0;
    w_way = '0; r_way = '0;
    idle_in();
    repeat (3) cyc();
    @(negedge clk);
    chk("rst_busy", {64'd0, busy}, 65'd0);
    chk("rst_stall", {61'd0, stall_cnt}, 65'd0);
    chk("rst_outs", {60'd0, lock_req, desc_valid, starve, w_ready, r_ready}, 65'd0);
    chk("rst_desc", {1'b0, desc_o}, 65'd0);
    chk("rst_lock", {49'd0, lock_index, lock_way}, 65'd0);
    cyc();
    rst = 0;

    // single write
    w_valid = 1; w_index = 8'h05; w_way = 8'b0000_0100; w_desc = 64'h1111;
    @(negedge clk);
    chk("sw_ready", {63'd0, w_ready, r_ready}, 65'b10);
    cyc();
    w_valid = 0;
    @(negedge clk);
    chk("sw_lockreq", {64'd0, lock_req}, 65'd1);
    chk("sw_lockidx", {57'd0, lock_index}, 65'h05);
    chk("sw_lockway", {57'd0, lock_way}, 65'h04);
    cyc();
    @(negedge clk);
    chk("sw_dvalid", {63'd0, desc_valid, desc_src}, 65'b10);
    chk("sw_stall", {61'd0, stall_cnt}, 65'd0);
    chk("sw_noreq", {64'd0, lock_req}, 65'd0);
    cyc();

    // fairness
    do_reset();
    n_lock = 0; n_acc = 0;
    for (int i = 0; i < 24; i++) begin
      if (i > 0) cyc();
      w_valid = 1; r_valid = 1;
      w_desc = 64'hA000 + 64'(i); r_desc = 64'hB000 + 64'(i);
      w_index = 8'(i); r_index = 8'(i + 100);
      @(negedge clk);
    end
    cyc();
    idle_in();
    @(negedge clk);
    chk("fair_acc", 65'(n_acc), 65'd8);
    chk("fair_locks", 65'(n_lock), 65'd8);

    // blocked read line
    cyc();
    n_lock = 0;
    r_valid = 1; r_desc = 64'hBEEF; r_index = 8'h33; r_way = 8'h10;
    locked = 1;
    @(negedge clk);
    chk("blk_rready", {63'd0, w_ready, r_ready}, 65'b01);
    for (int k = 1; k <= 6; k++) begin
      cyc();
      r_valid = 0; w_valid = 1;
      locked = (k <= 5);
      @(negedge clk);
      chk("blk_stall", {61'd0, stall_cnt}, 65'(k - 1));
      chk("blk_req", {64'd0, lock_req}, 65'(k == 6));
      chk("blk_wready", {64'd0, w_ready}, 65'd0);
    end
    cyc();
    locked = 0;
    @(negedge clk);
    chk("blk_send", {59'd0, desc_valid, desc_src, stall_cnt}, {59'd0, 2'b11, 4'd5});
    chk("blk_wready2", {64'd0, w_ready}, 65'd0);
    cyc();
    idle_in();
    @(negedge clk);
    chk("blk_locks", 65'(n_lock), 65'd1);

    // backpressure
    cyc();
    n_lock = 0;
    w_valid = 1; w_desc = 64'hCAFE_0001; desc_ready = 0;
    cyc();
    r_valid = 1; w_desc = 64'hDEAD;
    @(negedge clk);
    chk("bp_check_rdy", {63'd0, w_ready, r_ready}, 65'd0);
    for (int k = 0; k < 4; k++) begin
      cyc();
      @(negedge clk);
      chk("bp_valid", {64'd0, desc_valid}, 65'd1);
      chk("bp_desc", {1'b0, desc_o}, 65'hCAFE_0001);
      chk("bp_rdy", {63'd0, w_ready, r_ready}, 65'd0);
    end
    cyc();
    desc_ready = 1; w_valid = 0; r_valid = 0;
    @(negedge clk);
    cyc();
    @(negedge clk);
    chk("bp_idle", {64'd0, busy}, 65'd0);
    chk("bp_locks", 65'(n_lock), 65'd1);

    // starvation and saturation
    cyc();
    w_valid = 1; w_desc = 64'h5757; locked = 1;
    for (int k = 1; k <= 20; k++) begin
      cyc();
      w_valid = 0;
      @(negedge clk);
      chk("st_stall", {61'd0, stall_cnt}, 65'((k - 1) > 15 ? 15 : (k - 1)));
      chk("st_starve", {64'd0, starve}, 65'((k - 1) >= 10));
    end
    cyc();
    locked = 0;
    @(negedge clk);
    chk("st_sat", {60'd0, starve, stall_cnt}, {60'd0, 1'b1, 4'd15});
    cyc();
    @(negedge clk);
    chk("st_send", {63'd0, desc_valid, starve}, 65'b11);
    cyc();
    w_valid = 1; w_desc = 64'h6868;
    @(negedge clk);
    chk("st_idle_starve", {64'd0, starve}, 65'd1);
    cyc();
    w_valid = 0;
    @(negedge clk);
    chk("st_clear", {60'd0, starve, stall_cnt}, 65'd0);
    cyc();
    @(negedge clk);

    // reset mid-CHECK
    cyc();
    n_lock = 0;
    w_valid = 1; w_desc = 64'h7777; locked = 1;
    repeat (3) begin
      cyc();
      w_valid = 0;
    end
    rst = 1;
    cyc();
    rst = 0;
    w_valid = 1; r_valid = 1;
    w_desc = 64'h8001; r_desc = 64'h9001;
    @(negedge clk);
    chk("rm_busy", {64'd0, busy}, 65'd0);
    chk("rm_stall", {61'd0, stall_cnt}, 65'd0);
    chk("rm_req", {64'd0, lock_req}, 65'd0);
    chk("rm_grant", {63'd0, w_ready, r_ready}, 65'b10);
    locked = 0;
    repeat (6) cyc();
    idle_in();
    repeat (4) cyc();
    @(negedge clk);
    chk("rm_locks", 65'(n_lock), 65'd2);
    chk("sb_drained", 65'(sb_q.size()), 65'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
